// File: rtl/attention_core_mlane.sv
// Multi-lane q/k/v attention MAC: accumulates per-lane q*k and q*k*v over a job; ATTN_MLANE_SAT_EN saturates out_data.
// out_valid rises 2 edges after the last beat is accepted; in_ready drops once the job's beats are taken, result held until out_ready.
module attention_core_mlane #(
   parameter int DATA_WIDTH  = 16,
   parameter int LANES       = 4,
   parameter int K_TILE      = 16,
   parameter int SCORE_OUT_W = 32
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          cfg_start,
   input  logic                          cfg_clear_perf,
   input  logic [15:0]                   cfg_k_beats,
   input  logic [5:0]                    cfg_shift,
   output logic                          busy,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [LANES*DATA_WIDTH-1:0]   q_vec,
   input  logic [LANES*DATA_WIDTH-1:0]   k_vec,
   input  logic [LANES*DATA_WIDTH-1:0]   v_vec,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [DATA_WIDTH-1:0]         out_data,
   output logic [SCORE_OUT_W-1:0]        out_score,
   output logic [31:0]                   perf_cycle_count,
   output logic [31:0]                   perf_mac_count,
   output logic [31:0]                   perf_stall_count
);

   localparam int PW  = 2*DATA_WIDTH;
   localparam int PVW = 3*DATA_WIDTH;
   localparam int SW  = 2*DATA_WIDTH + 16;
   localparam int VW  = 3*DATA_WIDTH + 16;

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_OUT} state_t;

   state_t                 state;
   logic [15:0]            k_target;
   logic [15:0]            issued;
   logic [15:0]            done_count;
   logic [5:0]             shift_lat;
   logic signed [SW-1:0]   score_acc;
   logic signed [VW-1:0]   value_acc;

   logic signed [PW-1:0]   p_c   [LANES];
   logic signed [PVW-1:0]  pv_c  [LANES];
   logic signed [PW-1:0]   s1_p  [LANES];
   logic signed [PVW-1:0]  s1_pv [LANES];
   logic                   s1_vld;
   logic signed [SW-1:0]   sum_s;
   logic signed [VW-1:0]   sum_v;
   logic signed [SW-1:0]   s2_score;
   logic signed [VW-1:0]   s2_value;
   logic                   s2_vld;

   logic                   fire_in;
   logic                   fire_out;
   logic                   start_job;
   logic                   stall_cond;
   logic signed [VW-1:0]   shifted;
   logic                   unused_bits;

   assign busy       = (state != ST_IDLE);
   assign in_ready   = (state == ST_RUN) && (issued < k_target);
   assign fire_in    = in_valid && in_ready;
   assign fire_out   = (state == ST_OUT) && out_valid && out_ready;
   assign start_job  = cfg_start && ((state == ST_IDLE) || fire_out);
   assign stall_cond = ((state == ST_RUN) && in_ready && !in_valid) ||
                       ((state == ST_OUT) && !out_ready);

   always_comb begin
      for (int i = 0; i < LANES; i++) begin
         p_c[i]  = PW'($signed(q_vec[i*DATA_WIDTH +: DATA_WIDTH])) *
                   PW'($signed(k_vec[i*DATA_WIDTH +: DATA_WIDTH]));
         pv_c[i] = PVW'(p_c[i]) * PVW'($signed(v_vec[i*DATA_WIDTH +: DATA_WIDTH]));
      end
   end

   always_comb begin
      sum_s = '0;
      sum_v = '0;
      for (int i = 0; i < LANES; i++) begin
         sum_s = sum_s + SW'(s1_p[i]);
         sum_v = sum_v + VW'(s1_pv[i]);
      end
   end

   // Two-stage pipe: products, then lane adder tree; valids track one beat per cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_vld   <= 1'b0;
         s2_vld   <= 1'b0;
         s2_score <= '0;
         s2_value <= '0;
         for (int i = 0; i < LANES; i++) begin
            s1_p[i]  <= '0;
            s1_pv[i] <= '0;
         end
      end else begin
         s1_vld <= fire_in;
         s2_vld <= s1_vld;
         if (fire_in) begin
            for (int i = 0; i < LANES; i++) begin
               s1_p[i]  <= p_c[i];
               s1_pv[i] <= pv_c[i];
            end
         end
         if (s1_vld) begin
            s2_score <= sum_s;
            s2_value <= sum_v;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         out_valid  <= 1'b0;
         k_target   <= '0;
         issued     <= '0;
         done_count <= '0;
         shift_lat  <= '0;
         score_acc  <= '0;
         value_acc  <= '0;
      end else begin
         if (s2_vld) begin
            score_acc  <= score_acc + s2_score;
            value_acc  <= value_acc + s2_value;
            done_count <= done_count + 16'd1;
         end
         if (fire_in)
            issued <= issued + 16'd1;

         case (state)
            ST_IDLE: begin
               if (cfg_start)
                  state <= ST_RUN;
            end
            ST_RUN: begin
               if (fire_in && (issued == k_target - 16'd1))
                  state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (s2_vld && (done_count == k_target - 16'd1)) begin
                  state     <= ST_OUT;
                  out_valid <= 1'b1;
               end
            end
            ST_OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= cfg_start ? ST_RUN : ST_IDLE;
               end
            end
            default: begin
               state     <= ST_IDLE;
               out_valid <= 1'b0;
            end
         endcase

         // Pipeline is empty whenever a job can start, so clearing here loses nothing.
         if (start_job) begin
            k_target   <= (cfg_k_beats == 16'd0) ? 16'(K_TILE) : cfg_k_beats;
            shift_lat  <= cfg_shift;
            issued     <= '0;
            done_count <= '0;
            score_acc  <= '0;
            value_acc  <= '0;
         end
      end
   end

   always_comb begin
      shifted = value_acc >>> shift_lat;
`ifdef ATTN_MLANE_SAT_EN
      if (shifted > $signed({{(VW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}}))
         out_data = {1'b0, {(DATA_WIDTH-1){1'b1}}};
      else if (shifted < $signed({{(VW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}}))
         out_data = {1'b1, {(DATA_WIDTH-1){1'b0}}};
      else
         out_data = shifted[DATA_WIDTH-1:0];
`else
      out_data = shifted[DATA_WIDTH-1:0];
`endif
   end

   assign out_score   = score_acc[SCORE_OUT_W-1:0];
   assign unused_bits = ^{score_acc[SW-1:SCORE_OUT_W], shifted[VW-1:DATA_WIDTH]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_cycle_count <= '0;
         perf_mac_count   <= '0;
         perf_stall_count <= '0;
      end else if (cfg_clear_perf) begin
         perf_cycle_count <= '0;
         perf_mac_count   <= '0;
         perf_stall_count <= '0;
      end else begin
         if (state != ST_IDLE)
            perf_cycle_count <= perf_cycle_count + 32'd1;
         if (s2_vld)
            perf_mac_count <= perf_mac_count + 32'(LANES);
         if (stall_cond)
            perf_stall_count <= perf_stall_count + 32'd1;
      end
   end

endmodule

// File: tb/tb_attention_core_mlane.sv
// Scoreboard bench for attention_core_mlane: directed jobs push expected results, a monitor pops on each handshake.
module tb_attention_core_mlane;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cfg_start;
   logic        cfg_clear_perf;
   logic [15:0] cfg_k_beats;
   logic [5:0]  cfg_shift;
   logic        busy;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] q_vec, k_vec, v_vec;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic [31:0] out_score;
   logic [31:0] perf_cycle_count, perf_mac_count, perf_stall_count;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [15:0] d;
      logic [31:0] s;
      string       nm;
   } exp_t;
   exp_t exp_q[$];
   exp_t e;

   attention_core_mlane dut (
      .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_clear_perf(cfg_clear_perf),
      .cfg_k_beats(cfg_k_beats), .cfg_shift(cfg_shift), .busy(busy),
      .in_valid(in_valid), .in_ready(in_ready), .q_vec(q_vec), .k_vec(k_vec), .v_vec(v_vec),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_score(out_score),
      .perf_cycle_count(perf_cycle_count), .perf_mac_count(perf_mac_count),
      .perf_stall_count(perf_stall_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] pk(input int a, input int b, input int c, input int d);
      return {16'(d), 16'(c), 16'(b), 16'(a)};
   endfunction

   task automatic push(input string nm, input logic [15:0] d, input logic [31:0] s);
      exp_t x;
      x.d = d; x.s = s; x.nm = nm;
      exp_q.push_back(x);
   endtask

   task automatic start_job(input logic [15:0] k, input logic [5:0] sh);
      cfg_k_beats = k;
      cfg_shift   = sh;
      cfg_start   = 1'b1;
      tick();
      cfg_start   = 1'b0;
   endtask

   task automatic clear_perf();
      cfg_clear_perf = 1'b1;
      tick();
      cfg_clear_perf = 1'b0;
   endtask

   task automatic send_beat(input logic [63:0] q, input logic [63:0] k, input logic [63:0] v);
      int n;
      q_vec = q; k_vec = k; v_vec = v;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 50) begin
         tick();
         n++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL send_beat: in_ready=0 after 50 cycles, expected 1");
      end else begin
         tick();
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_idle(input string nm);
      int n;
      n = 0;
      while (busy && n < 300) begin
         tick();
         n++;
      end
      chk({nm, "_idle"}, busy, 1'b0);
   endtask

   // Monitor: a result transfers at the next posedge when valid and ready are both seen here.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got data=%0h score=%0h, expected none", out_data, out_score);
         end else begin
            e = exp_q.pop_front();
            chk({e.nm, "_data"}, out_data, e.d);
            chk({e.nm, "_score"}, out_score, e.s);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      longint sc, va;
      logic [15:0] d0;
      rst_n = 1'b0; cfg_start = 1'b0; cfg_clear_perf = 1'b0;
      cfg_k_beats = '0; cfg_shift = '0;
      in_valid = 1'b0; q_vec = '0; k_vec = '0; v_vec = '0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_score", out_score, 0);
      chk("rst_perf_cycle", perf_cycle_count, 0);
      rst_n = 1'b1;
      tick();

      // Single beat, latency 2 edges after acceptance
      start_job(16'd1, 6'd8);
      chk("t1_busy", busy, 1);
      chk("t1_in_ready", in_ready, 1);
      push("t1", 16'd10, 32'd10);
      send_beat(pk(1, 2, 3, 4), pk(1, 1, 1, 1), pk(256, 256, 256, 256));
      chk("t1_lat0", out_valid, 0);
      tick();
      chk("t1_lat1", out_valid, 0);
      tick();
      chk("t1_lat2", out_valid, 1);
      wait_idle("t1");
      chk("t1_perf_mac", perf_mac_count, 4);
      chk("t1_perf_cycle", perf_cycle_count, 4);

      // Default depth with 3 input gaps
      clear_perf();
      chk("t2_perf_cleared", perf_mac_count, 0);
      sc = 0; va = 0;
      for (int j = 0; j < 16; j++)
         for (int i = 0; i < 4; i++) begin
            sc += longint'((j+i-5) * (2-i));
            va += longint'((j+i-5) * (2-i) * (j-i));
         end
      push("t2", 16'(va >>> 2), 32'(sc));
      start_job(16'd0, 6'd2);
      for (int j = 0; j < 16; j++) begin
         send_beat(pk(j-5, j-4, j-3, j-2), pk(2, 1, 0, -1), pk(j, j-1, j-2, j-3));
         if (j == 3 || j == 7 || j == 11)
            tick();
      end
      chk("t2_in_ready_after16", in_ready, 0);
      q_vec = pk(999, 999, 999, 999); k_vec = q_vec; v_vec = q_vec;
      in_valid = 1'b1;
      repeat (3) tick();
      in_valid = 1'b0;
      wait_idle("t2");
      chk("t2_perf_mac", perf_mac_count, 64);
      chk("t2_perf_stall", perf_stall_count, 3);

      // Back-pressure then back-to-back start
      clear_perf();
      out_ready = 1'b0;
      push("t3a", 16'd24, 32'd6);
      start_job(16'd1, 6'd0);
      send_beat(pk(2, 0, 0, 0), pk(3, 0, 0, 0), pk(4, 0, 0, 0));
      for (int n = 0; n < 50 && !out_valid; n++)
         tick();
      chk("t3_out_valid", out_valid, 1);
      d0 = out_data;
      chk("t3_first_data", d0, 16'd24);
      for (int n = 0; n < 5; n++) begin
         tick();
         chk("t3_hold_data", out_data, 16'd24);
      end
      chk("t3_perf_stall", perf_stall_count, 5);
      out_ready = 1'b1;
      cfg_k_beats = 16'd2;
      cfg_shift = 6'd1;
      cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
      chk("t3_b2b_in_ready", in_ready, 1);
      chk("t3_b2b_busy", busy, 1);
      chk("t3_b2b_out_valid", out_valid, 0);
      push("t3b", 16'd11, 32'd9);
      send_beat(pk(1, -2, 3, 0), pk(1, 1, 1, 1), pk(2, 2, 2, 2));
      send_beat(pk(4, 0, 0, 1), pk(2, 0, 0, -1), pk(3, 0, 0, 5));
      wait_idle("t3b");

      // Overflow of the low DATA_WIDTH bits
`ifdef ATTN_MLANE_SAT_EN
      push("t4", 16'h7FFF, 32'hFFFC0004);
`else
      push("t4", 16'hFFFC, 32'hFFFC0004);
`endif
      start_job(16'd1, 6'd0);
      send_beat(pk(32767, 32767, 32767, 32767), pk(32767, 32767, 32767, 32767),
                pk(32767, 32767, 32767, 32767));
      wait_idle("t4");

      // Arithmetic shift of a negative value
      push("t5", 16'hFFFF, 32'hFFFFFFFF);
      start_job(16'd1, 6'd8);
      send_beat(pk(-1, 0, 0, 0), pk(1, 0, 0, 0), pk(256, 0, 0, 0));
      wait_idle("t5");

      // Reset mid-run discards the job
      start_job(16'd8, 6'd0);
      for (int j = 0; j < 3; j++)
         send_beat(pk(100, 200, 300, 400), pk(5, 6, 7, 8), pk(9, 9, 9, 9));
      tick();
      rst_n = 1'b0;
      #1;
      chk("t6_rst_busy", busy, 0);
      chk("t6_rst_in_ready", in_ready, 0);
      chk("t6_rst_out_valid", out_valid, 0);
      chk("t6_rst_out_data", out_data, 0);
      chk("t6_rst_out_score", out_score, 0);
      chk("t6_rst_perf_mac", perf_mac_count, 0);
      chk("t6_rst_perf_stall", perf_stall_count, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();
      push("t6", 16'd8, 32'd8);
      start_job(16'd2, 6'd0);
      send_beat(pk(1, 1, 1, 1), pk(1, 1, 1, 1), pk(1, 1, 1, 1));
      send_beat(pk(1, 1, 1, 1), pk(1, 1, 1, 1), pk(1, 1, 1, 1));
      wait_idle("t6");
      chk("t6_perf_mac", perf_mac_count, 8);

      repeat (3) tick();
      chk("scoreboard_empty", 64'(exp_q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
